// File: rtl/vga_timing_controller.sv
// VGA raster sequencer: h/v counters, registered hsync/vsync/video_on, frame-gated run/idle FSM.
// Latency: counters and decoded outputs update on the same pix_en edge; line_end/frame_end are combinational.
// Backpressure: none; pix_en=0 freezes all state, and run is only honoured at frame boundaries.
module vga_timing_controller #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter logic        SYNC_ACTIVE = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_en,
  input  logic       run,
  output logic       busy,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       line_end,
  output logic       frame_end
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [9:0] pix_x_q, pix_x_d;
  logic [9:0] pix_y_q, pix_y_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       video_on_q, video_on_d;

  logic [9:0] x_nxt, y_nxt;
  logic       load_dec;

  assign busy      = (state_q == S_RUN);
  assign line_end  = busy & pix_en & (pix_x_q == H_LAST);
  assign frame_end = line_end & (pix_y_q == V_LAST);

  assign hsync    = hsync_q;
  assign vsync    = vsync_q;
  assign video_on = video_on_q;
  assign pix_x    = pix_x_q;
  assign pix_y    = pix_y_q;

  // Raster position one pixel ahead, wrapping line then frame.
  always_comb begin
    x_nxt = pix_x_q + 10'd1;
    y_nxt = pix_y_q;
    if (pix_x_q == H_LAST) begin
      x_nxt = '0;
      y_nxt = (pix_y_q == V_LAST) ? '0 : pix_y_q + 10'd1;
    end
  end

  // FSM next state, counter update and output decode from the next position.
  always_comb begin
    state_d    = state_q;
    pix_x_d    = pix_x_q;
    pix_y_d    = pix_y_q;
    hsync_d    = hsync_q;
    vsync_d    = vsync_q;
    video_on_d = video_on_q;
    load_dec   = 1'b0;

    if (pix_en) begin
      case (state_q)
        S_IDLE: begin
          if (run) begin
            state_d  = S_RUN;
            pix_x_d  = '0;
            pix_y_d  = '0;
            load_dec = 1'b1;
          end
        end
        S_RUN: begin
          if (frame_end && !run) begin
            state_d    = S_IDLE;
            pix_x_d    = '0;
            pix_y_d    = '0;
            hsync_d    = ~SYNC_ACTIVE;
            vsync_d    = ~SYNC_ACTIVE;
            video_on_d = 1'b0;
          end else begin
            pix_x_d  = x_nxt;
            pix_y_d  = y_nxt;
            load_dec = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Decode the position the counters are about to hold so outputs stay aligned with them.
    if (load_dec) begin
      hsync_d    = ((pix_x_d >= HS_START) && (pix_x_d < HS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vsync_d    = ((pix_y_d >= VS_START) && (pix_y_d < VS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      video_on_d = (pix_x_d < H_VIS) && (pix_y_d < V_VIS);
    end
  end

  // State register; reset drops straight to idle with syncs deasserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pix_x_q    <= '0;
      pix_y_q    <= '0;
      hsync_q    <= ~SYNC_ACTIVE;
      vsync_q    <= ~SYNC_ACTIVE;
      video_on_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pix_x_q    <= pix_x_d;
      pix_y_q    <= pix_y_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      video_on_q <= video_on_d;
    end
  end

endmodule

// File: tb/tb_vga_timing_controller.sv
// Bench for vga_timing_controller with a shrunken raster (20 x 12) so whole frames fit in a short run.
// Latency: model tracks a linear raster index; outputs compared every falling edge.
// Backpressure: pix_en comes from a 1-in-5 divider that can be stalled.
module tb_vga_timing_controller;

  localparam int HA = 10, HF = 3, HS = 4, HB = 3;
  localparam int VA = 6,  VF = 2, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;  // 20
  localparam int VT = VA + VF + VS + VB;  // 12
  localparam int LIMIT = 3000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pix_en = 1'b0;
  logic       run = 1'b0;
  logic       busy, hsync, vsync, video_on, line_end, frame_end;
  logic [9:0] pix_x, pix_y;
  bit         stall = 1'b0;

  int checks = 0;
  int passes = 0;

  vga_timing_controller #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_ACTIVE(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .run(run),
    .busy(busy), .hsync(hsync), .vsync(vsync), .video_on(video_on),
    .pix_x(pix_x), .pix_y(pix_y), .line_end(line_end), .frame_end(frame_end)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  // Pixel-tick divider: one pix_en per 5 clks, changed just after the rising edge.
  initial begin
    int div = 0;
    forever begin
      @(posedge clk);
      #1;
      div = (div == 4) ? 0 : div + 1;
      pix_en = (div == 0) && !stall;
    end
  end

  // Reference model: scanning flag plus a linear raster index.
  bit m_run = 1'b0;
  int m_p = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run = 1'b0;
      m_p = 0;
    end else if (pix_en) begin
      if (!m_run) begin
        if (run) begin
          m_run = 1'b1;
          m_p = 0;
        end
      end else if (m_p == HT * VT - 1) begin
        m_p = 0;
        if (!run) m_run = 1'b0;
      end else begin
        m_p++;
      end
    end
  end

  // Compare every DUT output against the model on each falling edge.
  always @(negedge clk) begin
    int mx, my, e_hs, e_vs, e_vid, e_le, e_fe;
    mx = m_p % HT;
    my = m_p / HT;
    e_hs  = (m_run && mx >= HA + HF && mx < HA + HF + HS) ? 0 : 1;
    e_vs  = (m_run && my >= VA + VF && my < VA + VF + VS) ? 0 : 1;
    e_vid = (m_run && mx < HA && my < VA) ? 1 : 0;
    e_le  = (m_run && pix_en && mx == HT - 1) ? 1 : 0;
    e_fe  = (e_le == 1 && my == VT - 1) ? 1 : 0;
    check("busy", int'(busy), int'(m_run));
    check("pix_x", int'(pix_x), mx);
    check("pix_y", int'(pix_y), my);
    check("hsync", int'(hsync), e_hs);
    check("vsync", int'(vsync), e_vs);
    check("video_on", int'(video_on), e_vid);
    check("line_end", int'(line_end), e_le);
    check("frame_end", int'(frame_end), e_fe);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_pos(input int x, input int y, input string name);
    int n = 0;
    while (!(int'(pix_x) == x && int'(pix_y) == y) && n < LIMIT) begin
      step();
      n++;
    end
    if (n >= LIMIT) check({"reach_", name}, 0, 1);
  endtask

  // sel: 0 = busy, 1 = line_end, 2 = frame_end
  task automatic wait_cond(input int sel, input string name);
    int n = 0;
    while (n < LIMIT) begin
      if (sel == 0 && busy) break;
      if (sel == 1 && line_end) break;
      if (sel == 2 && frame_end) break;
      step();
      n++;
    end
    if (n >= LIMIT) check({"reach_", name}, 0, 1);
  endtask

  initial begin
    int sx, sh, sv;
    // Reset held with run high and pix_en ticking.
    run = 1'b1;
    repeat (20) step();
    check("rst_busy", int'(busy), 0);
    check("rst_x", int'(pix_x), 0);
    check("rst_y", int'(pix_y), 0);
    check("rst_video", int'(video_on), 0);
    check("rst_hsync", int'(hsync), 1);
    check("rst_vsync", int'(vsync), 1);

    rst_n = 1'b1;
    wait_cond(0, "start");
    check("start_x", int'(pix_x), 0);
    check("start_y", int'(pix_y), 0);
    check("start_video", int'(video_on), 1);
    check("start_hsync", int'(hsync), 1);

    // Line timing: visible 0..9, hsync low 13..16, line_end at 19.
    wait_pos(9, 0, "x9");
    check("vid_x9", int'(video_on), 1);
    wait_pos(10, 0, "x10");
    check("vid_x10", int'(video_on), 0);
    wait_pos(12, 0, "x12");
    check("hs_x12", int'(hsync), 1);
    wait_pos(13, 0, "x13");
    check("hs_x13", int'(hsync), 0);
    wait_pos(16, 0, "x16");
    check("hs_x16", int'(hsync), 0);
    wait_pos(17, 0, "x17");
    check("hs_x17", int'(hsync), 1);
    wait_cond(1, "line_end");
    check("le_x", int'(pix_x), 19);
    check("le_y", int'(pix_y), 0);
    step();
    check("wrap_x", int'(pix_x), 0);
    check("wrap_y", int'(pix_y), 1);
    check("le_width", int'(line_end), 0);

    // Frame timing: vsync low on lines 8..9, frame_end at (19,11).
    wait_pos(0, 6, "y6");
    check("vid_y6", int'(video_on), 0);
    wait_pos(19, 7, "y7");
    check("vs_y7", int'(vsync), 1);
    wait_pos(0, 8, "y8");
    check("vs_y8", int'(vsync), 0);
    wait_pos(19, 9, "y9");
    check("vs_y9", int'(vsync), 0);
    wait_pos(0, 10, "y10");
    check("vs_y10", int'(vsync), 1);
    wait_cond(2, "frame_end");
    check("fe_x", int'(pix_x), 19);
    check("fe_y", int'(pix_y), 11);
    step();
    check("fwrap_busy", int'(busy), 1);
    check("fwrap_x", int'(pix_x), 0);
    check("fwrap_y", int'(pix_y), 0);
    check("fwrap_video", int'(video_on), 1);

    // pix_en stall mid-line freezes everything.
    wait_pos(5, 2, "stall_pos");
    stall = 1'b1;
    pix_en = 1'b0;
    sx = int'(pix_x); sh = int'(hsync); sv = int'(video_on);
    repeat (37) step();
    check("stall_x", int'(pix_x), 5);
    check("stall_y", int'(pix_y), 2);
    check("stall_hsync", sh, int'(hsync));
    check("stall_video", int'(video_on), 1);
    stall = 1'b0;
    wait_pos(6, 2, "resume");
    check("resume_x", int'(pix_x), sx + 1);

    // Stop request mid-frame completes the frame first.
    wait_pos(4, 3, "stop_pos");
    run = 1'b0;
    wait_cond(2, "stop_fe");
    check("stop_fe_x", int'(pix_x), 19);
    check("stop_fe_y", int'(pix_y), 11);
    check("stop_fe_busy", int'(busy), 1);
    step();
    check("stop_busy", int'(busy), 0);
    check("stop_x", int'(pix_x), 0);
    check("stop_video", int'(video_on), 0);
    check("stop_hsync", int'(hsync), 1);
    repeat (30) step();
    check("idle_busy", int'(busy), 0);
    run = 1'b1;
    wait_cond(0, "restart");
    check("restart_x", int'(pix_x), 0);
    check("restart_y", int'(pix_y), 0);

    // Asynchronous reset while both syncs are asserted.
    wait_pos(14, 8, "arst_pos");
    check("pre_arst_hsync", int'(hsync), 0);
    check("pre_arst_vsync", int'(vsync), 0);
    rst_n = 1'b0;
    #1;
    check("arst_hsync", int'(hsync), 1);
    check("arst_vsync", int'(vsync), 1);
    check("arst_x", int'(pix_x), 0);
    check("arst_y", int'(pix_y), 0);
    check("arst_busy", int'(busy), 0);
    run = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (20) step();
    check("post_rst_idle", int'(busy), 0);
    run = 1'b1;
    wait_cond(0, "post_rst_start");
    check("post_rst_x", int'(pix_x), 0);
    repeat (10) step();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
